// File: rtl/inex_pkg.sv
// Shared types and constants for the inexact-recursion search entries.
// The register file and the branch generator both use this package.
package inex_pkg;

  localparam int unsigned ENT_FW    = 8;
  localparam int unsigned ENT_W     = 4 * ENT_FW;
  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned NUM_SLOTS = 9;
  localparam int unsigned SLOT_W    = 4;

  localparam int unsigned Z_LSB    = 24;
  localparam int unsigned OP_LSB   = 16;
  localparam int unsigned BASE_LSB = 8;
  localparam int unsigned I_LSB    = 0;

  typedef enum logic [ENT_FW-1:0] {
    OP_ROOT  = 8'd0,
    OP_MATCH = 8'd1,
    OP_MISM  = 8'd2,
    OP_INS   = 8'd3,
    OP_DEL   = 8'd4
  } op_e;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_e;

  typedef struct packed {
    logic [ENT_FW-1:0] z;
    logic [ENT_FW-1:0] op;
    logic [ENT_FW-1:0] base;
    logic [ENT_FW-1:0] i;
  } entry_t;

  // Assemble an entry from its fields using the documented bit positions.
  function automatic entry_t make_entry(input logic [ENT_FW-1:0] z,
                                        input op_e               op,
                                        input logic [1:0]        b,
                                        input logic [ENT_FW-1:0] i);
    logic [ENT_W-1:0] w;
    w = (ENT_W'(z) << Z_LSB) | (ENT_W'(op) << OP_LSB) |
        (ENT_W'(b) << BASE_LSB) | (ENT_W'(i) << I_LSB);
    return entry_t'(w);
  endfunction

endpackage

// File: rtl/inex_branch_gen_if.sv
// Parent-in / child-out bundle of the branch generator.
// master = the generator, slave = its environment (parent source + register file).
interface inex_branch_gen_if #(
  parameter int unsigned CNT_W = inex_pkg::CNT_WIDTH
);
  import inex_pkg::*;

  logic             in_valid;
  logic             in_ready;
  entry_t           in_entry;
  logic [1:0]       q_base;
  logic             w_full;
  logic             we;
  entry_t           w_data;
  logic             hit_valid;
  entry_t           hit_entry;
  logic             done;
  logic [CNT_W-1:0] child_cnt;

  modport master (
    input  in_valid, in_entry, q_base, w_full,
    output in_ready, we, w_data, hit_valid, hit_entry, done, child_cnt
  );

  modport slave (
    output in_valid, in_entry, q_base, w_full,
    input  in_ready, we, w_data, hit_valid, hit_entry, done, child_cnt
  );

endinterface

// File: rtl/inex_child_calc.sv
// Per-slot child generator: slot 0 = insertion, odd slots = deletions,
// even slots >= 2 = match/mismatch substitutions for bases A..T.
module inex_child_calc
  import inex_pkg::*;
#(
  parameter bit          EN_INDEL = 1'b1,
  parameter int unsigned FW       = ENT_FW
) (
  input  logic [SLOT_W-1:0] slot_i,
  input  entry_t            parent_i,
  input  logic [1:0]        q_base_i,
  output logic              applicable_c_o,
  output entry_t            child_c_o
);

  logic          z_pos_c;
  logic [FW-1:0] z_dec_c;
  logic [FW-1:0] i_dec_c;
  logic [1:0]    sub_base_c;
  logic          unused_parent_c;

  // op and base of the parent do not influence its children
  assign unused_parent_c = ^{parent_i.op, parent_i.base};

  always_comb begin
    z_pos_c        = (parent_i.z != '0);
    z_dec_c        = FW'(parent_i.z - 1'b1);
    i_dec_c        = FW'(parent_i.i - 1'b1);
    sub_base_c     = 2'(slot_i[3:1] - 3'd1);
    applicable_c_o = 1'b0;
    child_c_o      = '0;
    if (slot_i == '0) begin
      applicable_c_o = EN_INDEL && z_pos_c;
      child_c_o      = make_entry(z_dec_c, OP_INS, q_base_i, i_dec_c);
    end else if (slot_i[0]) begin
      applicable_c_o = EN_INDEL && z_pos_c;
      child_c_o      = make_entry(z_dec_c, OP_DEL, slot_i[2:1], parent_i.i);
    end else if (sub_base_c == q_base_i) begin
      applicable_c_o = 1'b1;
      child_c_o      = make_entry(parent_i.z, OP_MATCH, sub_base_c, i_dec_c);
    end else begin
      applicable_c_o = z_pos_c;
      child_c_o      = make_entry(z_dec_c, OP_MISM, sub_base_c, i_dec_c);
    end
  end

endmodule

// File: rtl/inex_branch_gen.sv
// Expands one parent search entry into up to nine children written to the
// register file; parents already at query index 0 are reported as hits.
module inex_branch_gen
  import inex_pkg::*;
#(
  parameter bit          EN_INDEL = 1'b1,
  parameter int unsigned FW       = ENT_FW,
  parameter int unsigned CNT_W    = CNT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  inex_branch_gen_if.master bus
);

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  entry_t            parent_q, parent_d;
  logic [1:0]        qbase_q, qbase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  entry_t            wdata_q, wdata_d;
  logic              hit_valid_q, hit_valid_d;
  entry_t            hit_entry_q, hit_entry_d;
  logic              done_q, done_d;
  logic              applicable_c;
  logic              advance_c;
  entry_t            child_c;

  inex_child_calc #(
    .EN_INDEL (EN_INDEL),
    .FW       (FW)
  ) u_child_calc (
    .slot_i         (slot_q),
    .parent_i       (parent_q),
    .q_base_i       (qbase_q),
    .applicable_c_o (applicable_c),
    .child_c_o      (child_c)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.we        = we_q;
  assign bus.w_data    = wdata_q;
  assign bus.hit_valid = hit_valid_q;
  assign bus.hit_entry = hit_entry_q;
  assign bus.done      = done_q;
  assign bus.child_cnt = cnt_q;

  // A non-applicable slot never waits on w_full
  assign advance_c = !applicable_c || !bus.w_full;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    parent_d    = parent_q;
    qbase_d     = qbase_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    hit_valid_d = 1'b0;
    hit_entry_d = hit_entry_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          parent_d = bus.in_entry;
          qbase_d  = bus.q_base;
          if (bus.in_entry.i == '0) begin
            hit_valid_d = 1'b1;
            hit_entry_d = bus.in_entry;
          end else begin
            state_d = ST_EMIT;
            slot_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_EMIT: begin
        // Stalled children stay visible on w_data with we low
        if (applicable_c) wdata_d = child_c;
        if (applicable_c && !bus.w_full) begin
          we_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (advance_c) begin
          slot_d = slot_q + SLOT_W'(1);
          if (slot_q == SLOT_W'(NUM_SLOTS - 1)) begin
            state_d = ST_IDLE;
            slot_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      parent_q    <= '0;
      qbase_q     <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      hit_valid_q <= 1'b0;
      hit_entry_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      parent_q    <= parent_d;
      qbase_q     <= qbase_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      hit_valid_q <= hit_valid_d;
      hit_entry_q <= hit_entry_d;
      done_q      <= done_d;
    end
  end

endmodule
